regfile_pc_commit: RTL and testbench
====================================

Name: regfile_pc_commit

Overview:
Architectural state holder directly downstream of the write-back output handler. Consumes register write requests (number, data, enable) and PC-redirect requests, and commits them into a 32x32 register file and the program counter. Serves two combinational read ports to decode, with same-cycle write bypass, and keeps a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NUM_REGS, 32, register count; fixed at 32 for MIPS, register 0 hardwired to zero.
DATA_W, 32, register and PC width.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  freezes all commits this cycle
rs_num  in  5  read port A address
rt_num  in  5  read port B address
rs_data  out  32  read port A data (combinational)
rt_data  out  32  read port B data (combinational)
rd_we  in  1  register write enable from write-back
reg_num_to_write  in  5  destination register number
reg_data_to_write  in  32  data to write
pc_we  in  1  PC redirect request (jump/branch taken)
pc_value  in  32  redirect target
pc  out  32  current program counter (registered)
pc_misaligned  out  1  sticky flag: a redirect target had nonzero bits [1:0]
retired_count  out  32  instructions committed since reset

Behaviour:
- Reset (rst=1 at rising edge): all 32 registers <= 0; pc <= RESET_PC; pc_misaligned <= 0; retired_count <= 0. Reset has priority over stall and all write requests; a write presented in the reset cycle is discarded.
- Register write: at rising edge, if !stall && rd_we && reg_num_to_write != 0, regs[reg_num_to_write] <= reg_data_to_write. Writes to register 0 are silently dropped; register 0 always reads 0.
- Reads: combinational. rs_data = 0 if rs_num == 0; else reg_data_to_write if (rd_we && !stall && reg_num_to_write == rs_num); else regs[rs_num]. Same for rt_data/rt_num. Both ports may read the same address.
- PC update each rising edge when !stall:
  - pc_we=1: pc <= {pc_value[31:2], 2'b00}. If pc_value[1:0] != 0, set pc_misaligned (sticky until reset).
  - pc_we=0: pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- rd_we and pc_we in the same cycle: both take effect (jal-style link plus redirect). Neither has priority over the other.
- stall=1: pc, registers, retired_count and pc_misaligned all hold. Reads remain live; no bypass is applied.
- retired_count: increments by 1 on every non-stalled, non-reset edge and wraps at 2^32.
- Latency: a write is visible via bypass in the same cycle and from the array from the next cycle. The new pc is visible one cycle after the edge.
- No X propagation: all outputs are defined from the first post-reset cycle.

Test Plan:
- Reset then 3 free-running cycles with RESET_PC=0x0040_0000 -> pc = 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C; retired_count = 3; all reads return 0.
- Write r5=0xDEAD_BEEF with rs_num=5 in the same cycle -> rs_data = 0xDEAD_BEEF combinationally (bypass). Next cycle with rd_we=0 -> rs_data = 0xDEAD_BEEF from the array.
- rd_we=1, reg_num_to_write=0, data 0x1234 -> rs_num=0 reads 0 in that cycle and afterwards.
- pc_we=1 with pc_value=0x0000_1002 -> pc = 0x0000_1000 next cycle; pc_misaligned=1 and stays 1 after later aligned jumps until rst.
- stall=1 for 2 cycles with rd_we=1 (r7 <= 0x55) and pc_we=1 -> pc, retired_count and r7 unchanged; rt_num=7 shows the old value (no bypass). Deassert stall -> commits proceed normally.
- pc=0xFFFF_FFFC with no redirect -> pc = 0x0000_0000. Simultaneous rd_we (r31 <= 0x8) and pc_we (0x100) -> r31=0x8 and pc=0x100 after one edge. Assert rst mid-sequence -> all state returns to reset values on the next edge.

Source files
------------

// File: rtl/regfile_pc_commit.sv
// Architectural commit stage: 32-entry register file with same-cycle write bypass,
// program counter with redirect and misalignment tracking, and a retired-instruction counter.
module regfile_pc_commit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [4:0]        rs_num,
  input  logic [4:0]        rt_num,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              rd_we,
  input  logic [4:0]        reg_num_to_write,
  input  logic [DATA_W-1:0] reg_data_to_write,
  input  logic              pc_we,
  input  logic [DATA_W-1:0] pc_value,
  output logic [DATA_W-1:0] pc,
  output logic              pc_misaligned,
  output logic [31:0]       retired_count
);

  logic              w_commit;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_regs [NUM_REGS];
  logic [4:0]        w_rd_num  [2];
  logic [DATA_W-1:0] w_rd_data [2];

  logic [DATA_W-1:0] r_pc;
  logic              r_misaligned;
  logic [31:0]       r_retired;

  assign w_commit = !stall;
  assign w_wr_en  = w_commit && rd_we && (reg_num_to_write != 5'd0);

  // Register 0 is a constant; every other entry is its own resettable register.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    if (gi == 0) begin : g_zero
      assign w_regs[gi] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_wr_en && (reg_num_to_write == 5'(gi))) begin
          r_q <= reg_data_to_write;
        end
      end
      assign w_regs[gi] = r_q;
    end
  end

  assign w_rd_num[0] = rs_num;
  assign w_rd_num[1] = rt_num;

  // Bypass only applies when the write will actually commit this edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    always_comb begin
      w_rd_data[gi] = w_regs[w_rd_num[gi]];
      if (w_rd_num[gi] == 5'd0) begin
        w_rd_data[gi] = '0;
      end else if (rd_we && w_commit && (reg_num_to_write == w_rd_num[gi])) begin
        w_rd_data[gi] = reg_data_to_write;
      end
    end
  end

  assign rs_data = w_rd_data[0];
  assign rt_data = w_rd_data[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
      r_retired    <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + 32'd1;
      if (pc_we) begin
        r_pc <= {pc_value[DATA_W-1:2], 2'b00};
        if (pc_value[1:0] != 2'b00) begin
          r_misaligned <= 1'b1;
        end
      end else begin
        r_pc <= r_pc + DATA_W'(4);
      end
    end
  end

  assign pc            = r_pc;
  assign pc_misaligned = r_misaligned;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_regfile_pc_commit.sv
// Directed plus randomized bench for regfile_pc_commit against an array-based
// architectural model; one line per failed comparison and a final summary line.
module tb_regfile_pc_commit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [4:0]  rs_num;
  logic [4:0]  rt_num;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_we;
  logic [4:0]  reg_num_to_write;
  logic [31:0] reg_data_to_write;
  logic        pc_we;
  logic [31:0] pc_value;
  logic [31:0] pc;
  logic        pc_misaligned;
  logic [31:0] retired_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_cnt;

  regfile_pc_commit #(
    .DATA_W  (32),
    .RESET_PC(32'h0040_0000),
    .NUM_REGS(32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .rs_num           (rs_num),
    .rt_num           (rt_num),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .rd_we            (rd_we),
    .reg_num_to_write (reg_num_to_write),
    .reg_data_to_write(reg_data_to_write),
    .pc_we            (pc_we),
    .pc_value         (pc_value),
    .pc               (pc),
    .pc_misaligned    (pc_misaligned),
    .retired_count    (retired_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural read: zero register, then committed-write forwarding, then stored value.
  function automatic logic [31:0] mread(input logic [4:0] n, input logic st, input logic we,
                                        input logic [4:0] wn, input logic [31:0] wd);
    if (n == 5'd0) return 32'd0;
    if (we && !st && wn == n) return wd;
    return m_regs[n];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc  = 32'h0040_0000;
    m_mis = 1'b0;
    m_cnt = 32'd0;
  endtask

  // One clock: drive, check combinational reads, advance model, check registered state.
  task automatic cyc(input logic st, input logic we, input logic [4:0] wn, input logic [31:0] wd,
                     input logic pwe, input logic [31:0] pv, input logic [4:0] a,
                     input logic [4:0] b, input string tag);
    stall = st; rd_we = we; reg_num_to_write = wn; reg_data_to_write = wd;
    pc_we = pwe; pc_value = pv; rs_num = a; rt_num = b;
    #1;
    chk({tag, "_rs"}, rs_data, mread(a, st, we, wn, wd));
    chk({tag, "_rt"}, rt_data, mread(b, st, we, wn, wd));
    if (!st) begin
      if (we && wn != 5'd0) m_regs[wn] = wd;
      if (pwe) begin
        m_pc = {pv[31:2], 2'b00};
        if (pv[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_mis"}, {31'd0, pc_misaligned}, {31'd0, m_mis});
    chk({tag, "_cnt"}, retired_count, m_cnt);
  endtask

  // Reset with a write and redirect presented that must both be discarded.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; rd_we = 1'b1; reg_num_to_write = 5'd3;
    reg_data_to_write = 32'hAAAA_5555; pc_we = 1'b1; pc_value = 32'h0000_0F03;
    @(posedge clk);
    #1;
    rst = 1'b0; rd_we = 1'b0; pc_we = 1'b0;
    model_reset();
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_mis", {31'd0, pc_misaligned}, 32'd0);
    chk("rst_cnt", retired_count, 32'd0);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'(2 * i), 5'(2 * i + 1), "rst_rd");
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rd_we = 1'b0; reg_num_to_write = '0; reg_data_to_write = '0;
    pc_we = 1'b0; pc_value = '0; rs_num = '0; rt_num = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset then three free-running cycles.
    do_reset();
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("fr_pc0", pc, 32'h0040_0000);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd1, 5'd31, "fr1");
    chk("fr_pc1", pc, 32'h0040_0004);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd2, 5'd30, "fr2");
    chk("fr_pc2", pc, 32'h0040_0008);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd3, 5'd29, "fr3");
    chk("fr_pc3", pc, 32'h0040_000C);
    chk("fr_cnt3", retired_count, 32'd3);

    // Same-cycle bypass, then array read.
    cyc(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 5'd5, 5'd0, "byp");
    rd_we = 1'b0; rs_num = 5'd5;
    #1;
    chk("arr_r5", rs_data, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5, 5'd5, "arr");

    // Writes to r0 never visible.
    cyc(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 32'd0, 5'd0, 5'd0, "r0w");
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd5, "r0r");

    // Misaligned redirect is truncated and the flag is sticky.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_1002, 5'd0, 5'd0, "mis");
    chk("mis_pc", pc, 32'h0000_1000);
    chk("mis_flag", {31'd0, pc_misaligned}, 32'd1);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_2000, 5'd0, 5'd0, "aln");
    chk("mis_sticky", {31'd0, pc_misaligned}, 32'd1);

    // Stall holds all state and suppresses bypass.
    cyc(1'b0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 32'd0, 5'd0, 5'd7, "r7init");
    cyc(1'b1, 1'b1, 5'd7, 32'h0000_0055, 1'b1, 32'h0000_3000, 5'd0, 5'd7, "stl1");
    chk("stl_r7", rt_data, 32'h0000_0077);
    cyc(1'b1, 1'b1, 5'd7, 32'h0000_0055, 1'b1, 32'h0000_3000, 5'd0, 5'd7, "stl2");
    cyc(1'b0, 1'b1, 5'd7, 32'h0000_0055, 1'b1, 32'h0000_3000, 5'd7, 5'd7, "unstl");
    chk("unstl_pc", pc, 32'h0000_3000);

    // PC wrap, then simultaneous link write and redirect.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'hFFFF_FFFC, 5'd0, 5'd0, "wrapj");
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0, "wrap");
    chk("wrap_pc", pc, 32'h0000_0000);
    cyc(1'b0, 1'b1, 5'd31, 32'h0000_0008, 1'b1, 32'h0000_0100, 5'd31, 5'd0, "jal");
    chk("jal_pc", pc, 32'h0000_0100);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd31, 5'd31, "jal_rd");

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pv;
      pv = $urandom;
      if ($urandom_range(0, 3) != 0) pv[1:0] = 2'b00;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
          $urandom_range(0, 3) == 0, pv, 5'($urandom), 5'($urandom), "rnd");
    end

    // Mid-sequence reset returns every register and counter to its reset value.
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
